float_unit_arbiter: RTL and testbench

FLOAT_UNIT_ARBITER -- requirements
Module: float_unit_arbiter

---
 rtl/float_unit_arbiter.sv | 135 +++++++++++++
 tb/tb_float_unit_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : float_unit_arbiter
// Purpose  : Round-robin arbiter sharing one pipelined floating-point unit
//            among N_REQ requesters. Grants are combinational. The winner's
//            operands are registered toward the unit. A tag pipeline matched
//            to the unit latency routes each result back to its owner.
// Ports    : clk, rst_n (async, active-low), en (issue enable)
//            req[N_REQ]           per-requester request
//            op_a/op_b[32*N_REQ]  flattened operands, requester i at [32i+:32]
//            gnt[N_REQ]           one-hot grant in the acceptance cycle
//            unit_a/unit_b/unit_valid  registered issue to the shared unit
//            unit_result          unit output, valid LATENCY cycles after issue
//            res_valid/res_id/res_data  returned result and its owner
//            op_count             saturating count of accepted ops
// Revision : 1.0 - initial release
// ============================================================================
module float_unit_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  op_a,
  input  logic [32*N_REQ-1:0]  op_b,
  output logic [N_REQ-1:0]     gnt,
  output logic [31:0]          unit_a,
  output logic [31:0]          unit_b,
  output logic                 unit_valid,
  input  logic [31:0]          unit_result,
  output logic                 res_valid,
  output logic [2:0]           res_id,
  output logic [31:0]          res_data,
  output logic [15:0]          op_count
);

  localparam logic [2:0]  LAST_ID   = 3'(N_REQ - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [2:0]  last_grant;
  logic [2:0]  win_id;
  logic        win_found;
  logic [31:0] win_a;
  logic [31:0] win_b;
  logic        accept;

  // Stage 0 is loaded together with unit_valid; stage LATENCY therefore lines
  // up with unit_result for the same op.
  logic        tag_valid [LATENCY+1];
  logic [2:0]  tag_id    [LATENCY+1];

  // Round-robin search without modulo arithmetic. Two passes, each scanning
  // downward so the lowest matching index is the last one written:
  //   pass 1: requesters at or below last_grant (wrap-around region)
  //   pass 2: requesters above last_grant, which take precedence
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) <= last_grant)) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) > last_grant)) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
  end

  // Grant qualification and operand selection for the winner.
  always_comb begin
    gnt   = '0;
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == win_id) begin
        gnt[i] = en && rst_n && win_found;
        win_a  = op_a[32*i +: 32];
        win_b  = op_b[32*i +: 32];
      end
    end
  end

  assign accept = |gnt;

  // Issue registers, round-robin pointer and op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_a     <= '0;
      unit_b     <= '0;
      unit_valid <= 1'b0;
      last_grant <= LAST_ID;
      op_count   <= '0;
    end else begin
      unit_valid <= accept;
      if (accept) begin
        unit_a     <= win_a;
        unit_b     <= win_b;
        last_grant <= win_id;
        if (op_count != COUNT_MAX) begin
          op_count <= op_count + 16'd1;
        end
      end
    end
  end

  // Tag pipeline. Idle slots carry id 0 so res_id reads 0 when no result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else begin
      tag_valid[0] <= accept;
      tag_id[0]    <= accept ? win_id : 3'd0;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign res_valid = tag_valid[LATENCY];
  assign res_id    = tag_id[LATENCY];
  // Result bits pass through untouched; zeroed only outside the strobe.
  assign res_data  = res_valid ? unit_result : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_float_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_unit_arbiter
// Purpose  : Self-checking bench for float_unit_arbiter (N_REQ=4, LATENCY=2).
//            A behavioural model tracks the round-robin pointer, the op count
//            and a queue of outstanding results keyed by due cycle; directed
//            scenarios plus a randomized phase are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_unit_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [N-1:0]      req;
  logic [32*N-1:0]   op_a;
  logic [32*N-1:0]   op_b;
  logic [N-1:0]      gnt;
  logic [31:0]       unit_a;
  logic [31:0]       unit_b;
  logic              unit_valid;
  logic [31:0]       unit_result;
  logic              res_valid;
  logic [2:0]        res_id;
  logic [31:0]       res_data;
  logic [15:0]       op_count;

  float_unit_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .op_a        (op_a),
    .op_b        (op_b),
    .gnt         (gnt),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_valid  (unit_valid),
    .unit_result (unit_result),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_data    (res_data),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int id;
    int due;
  } pend_t;

  pend_t       pend[$];
  int          lg;
  int          m_cnt;
  bit          m_uv;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          cyc;

  // Values observed in the most recent step, for directed checks
  logic [N-1:0] s_gnt;
  logic [31:0]  s_ua;
  logic [31:0]  s_ub;
  logic         s_uv;
  logic         s_rv;
  logic [2:0]   s_rid;
  logic [15:0]  s_cnt;
  int           rv_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    lg    = N - 1;
    m_cnt = 0;
    m_uv  = 1'b0;
    m_a   = '0;
    m_b   = '0;
  endtask

  // One clock cycle: sample at negedge, compare against the model, advance
  // the model, then move inputs just after the rising edge.
  task automatic step();
    int           w;
    logic [N-1:0] eg;
    bit           ev;
    @(negedge clk);
    w = -1;
    if (en && rst_n) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (lg + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("unit_valid", 32'(unit_valid), 32'(m_uv));
    check_eq("unit_a", unit_a, m_a);
    check_eq("unit_b", unit_b, m_b);
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    check_eq("res_valid", 32'(res_valid), 32'(ev));
    if (ev) begin
      check_eq("res_id", 32'(res_id), 32'(pend[0].id));
      void'(pend.pop_front());
    end
    check_eq("res_data", res_data, ev ? unit_result : 32'd0);
    check_eq("op_count", 32'(op_count), 32'(m_cnt));

    s_gnt = gnt; s_ua = unit_a; s_ub = unit_b; s_uv = unit_valid;
    s_rv = res_valid; s_rid = res_id; s_cnt = op_count;
    if (res_valid) rv_seen++;

    if (w >= 0) begin
      m_uv = 1'b1;
      m_a  = op_a[32*w +: 32];
      m_b  = op_b[32*w +: 32];
      lg   = w;
      if (m_cnt < 65535) m_cnt++;
      pend.push_back('{id: w, due: cyc + 1 + LAT});
    end else begin
      m_uv = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
    unit_result = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[32*i +: 32] = $urandom;
      op_b[32*i +: 32] = $urandom;
    end
  endtask

  logic [N-1:0] cont_seq [8];

  initial begin
    rst_n = 1'b0; en = 1'b1; req = '0; op_a = '0; op_b = '0;
    unit_result = $urandom;
    cyc = 0; rv_seen = 0;
    model_reset();

    // Single op
    do_reset();
    check_eq("reset_op_count", 32'(s_cnt), 32'd0);
    check_eq("reset_unit_valid", 32'(s_uv), 32'd0);
    op_a[31:0] = 32'h3F800000;
    op_b[31:0] = 32'h40000000;
    req = 4'b0001;
    step();
    check_eq("single_gnt", 32'(s_gnt), 32'h1);
    req = '0;
    step();
    check_eq("single_uv", 32'(s_uv), 32'd1);
    check_eq("single_ua", s_ua, 32'h3F800000);
    check_eq("single_ub", s_ub, 32'h40000000);
    step();
    step();
    check_eq("single_rv", 32'(s_rv), 32'd1);
    check_eq("single_rid", 32'(s_rid), 32'd0);

    // Full contention from reset
    do_reset();
    rand_ops();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      cont_seq[i] = s_gnt;
    end
    req = '0;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] e;
      e = '0;
      e[i % N] = 1'b1;
      check_eq("contention_order", 32'(cont_seq[i]), 32'(e));
    end
    for (int i = 0; i < 4; i++) step();
    check_eq("contention_count", 32'(s_cnt), 32'd8);

    // Fairness after skip: last grant at 1, then 1001
    do_reset();
    req = 4'b0001; step();
    req = 4'b0010; step();
    req = 4'b1001; step();
    check_eq("skip_first", 32'(s_gnt), 32'h8);
    step();
    check_eq("skip_second", 32'(s_gnt), 32'h1);
    req = '0;
    for (int i = 0; i < 4; i++) step();

    // Enable gating with ops in flight
    do_reset();
    rand_ops();
    rv_seen = 0;
    req = 4'b0001; step();
    req = 4'b0010; step();
    req = 4'b0100; step();
    en = 1'b0; req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("en_low_gnt", 32'(s_gnt), 32'd0);
    end
    check_eq("en_low_results", 32'(rv_seen), 32'd3);
    en = 1'b1; req = '0;

    // Reset mid-flight
    do_reset();
    req = 4'b0001; step();
    req = 4'b0010; step();
    req = '0;
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) step();
    check_eq("midflight_results", 32'(rv_seen), 32'd0);
    check_eq("midflight_count", 32'(s_cnt), 32'd0);
    req = 4'b1111; step();
    check_eq("midflight_next_gnt", 32'(s_gnt), 32'h1);
    req = '0;
    for (int i = 0; i < 4; i++) step();

    // Randomized phase with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      req = N'($urandom_range(0, (1 << N) - 1));
      en  = ($urandom_range(0, 7) != 0);
      rand_ops();
      step();
    end
    en = 1'b1; req = '0;
    for (int i = 0; i < 4; i++) step();

    // Saturation
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 65540; i++) step();
    req = '0;
    step();
    check_eq("sat_count", 32'(s_cnt), 32'h0000FFFF);
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
